axi_lite_led_bram_slave: RTL

AXI4-Lite responder for the PL side of the MPSoC base design, answering the PS general-purpose master port. It decodes one 17-bit window containing an 8-bit LED output register, a read-only ID word and a 256×32 scratch memory. It is a drop-in target for the LED-toggle and memory write/read-back sequences run by the MPSoC system bench.

---
 rtl/axi_lite_pkg.sv | 52 +++++
 rtl/byte_en_ram.sv | 46 ++++
 rtl/axi_lite_led_bram_slave.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared definitions for the AXI4-Lite LED/ID/scratch-memory
//               responder: response codes, FSM state types, address-map
//               offsets and the address-region decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] LED_OFS  = 32'h0000_0000;
    localparam logic [31:0] ID_OFS   = 32'h0000_0004;
    localparam logic [31:0] MEM_BASE = 32'h0001_0000;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_MEM  = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        RGN_LED  = 2'd0,
        RGN_ID   = 2'd1,
        RGN_MEM  = 2'd2,
        RGN_NONE = 2'd3
    } region_t;

    // Classify a byte address; the two low bits never take part in decode.
    function automatic region_t f_region(input logic [31:0] byte_addr, input int mem_depth);
        logic [31:0] a;
        a = byte_addr & 32'hFFFF_FFFC;
        if (a == LED_OFS)
            return RGN_LED;
        else if (a == ID_OFS)
            return RGN_ID;
        else if ((a >= MEM_BASE) && (a < (MEM_BASE + 32'(4 * mem_depth))))
            return RGN_MEM;
        else
            return RGN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_en_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_en_ram
// Description : Single-clock simple dual-port RAM, 32-bit words, four byte
//               enables, registered read with read-before-write behaviour.
//               Contents are not reset.
// Ports       : clk      - clock
//               i_we     - per-byte write enables
//               i_waddr  - write word index
//               i_wdata  - write data
//               i_re     - read enable (output register loads when high)
//               i_raddr  - read word index
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module byte_en_ram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    // One byte-wide array per lane keeps byte-enable inference simple.
    // Non-blocking write and read in the same block give read-before-write.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we[g])
                r_mem[i_waddr] <= i_wdata[8*g +: 8];
            if (i_re)
                r_q <= r_mem[i_raddr];
        end

        assign o_rdata[8*g +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_led_bram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_led_bram_slave
// Description : AXI4-Lite responder with an 8-bit LED register (0x00000),
//               a read-only ID word (0x00004) and a MEM_DEPTH x 32 scratch
//               memory at 0x10000. Independent write and read FSMs; all
//               outputs registered.
// Ports       : ACLK, ARESETn (synchronous, active-low)
//               s_axi_aw*/w*/b* - write address, data, response channels
//               s_axi_ar*/r*    - read address and data channels
//               leds            - LED register
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_led_bram_slave
    import axi_lite_pkg::*;
#(
    parameter int          ADDR_W    = 17,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] ID_VALUE  = 32'h4C45_4401
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [7:0]        leds
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t         r_wstate, w_wstate_nxt;
    logic              r_awready, w_awready_nxt;
    logic              r_wready, w_wready_nxt;
    logic              r_bvalid, w_bvalid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
    logic              r_aw_held, w_aw_held_nxt;
    logic              r_w_held, w_w_held_nxt;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [7:0]        r_leds;

    logic              w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_do_write;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    region_t           w_wr_rgn;
    logic [1:0]        w_wr_resp;
    logic [3:0]        w_ram_we;

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    assign w_aw_have = w_aw_hs || r_aw_held;
    assign w_w_have  = w_w_hs || r_w_held;

    // A channel captured in an earlier cycle wins over the live bus value.
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : s_axi_wdata;
    assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi_wstrb;

    // Gated by ARESETn so a write pending when reset arrives never lands.
    assign w_do_write = ARESETn && (r_wstate == W_IDLE) && w_aw_have && w_w_have;

    assign w_wr_rgn = f_region(32'(w_wr_addr), MEM_DEPTH);

    always_comb begin
        case (w_wr_rgn)
            RGN_ID:   w_wr_resp = RESP_SLVERR;
            RGN_NONE: w_wr_resp = RESP_DECERR;
            default:  w_wr_resp = RESP_OKAY;
        endcase
    end

    assign w_ram_we = (w_do_write && (w_wr_rgn == RGN_MEM)) ? w_wr_strb : 4'b0000;

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        case (r_wstate)
            W_IDLE: begin
                if (w_do_write) begin
                    w_wstate_nxt  = W_RESP;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = w_wr_resp;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                end else begin
                    w_aw_held_nxt = w_aw_have;
                    w_w_held_nxt  = w_w_have;
                    w_awready_nxt = !w_aw_have;
                    w_wready_nxt  = !w_w_have;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_aw_hs)
            r_awaddr <= s_axi_awaddr;
        if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            r_leds <= 8'h00;
        else if (w_do_write && (w_wr_rgn == RGN_LED) && w_wr_strb[0])
            r_leds <= w_wr_data[7:0];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t   r_rstate, w_rstate_nxt;
    logic        r_arready, w_arready_nxt;
    logic        r_rvalid, w_rvalid_nxt;
    logic [1:0]  r_rresp, w_rresp_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        w_ar_hs;
    region_t     w_rd_rgn;
    logic [31:0] w_ram_q;

    assign w_ar_hs  = s_axi_arvalid && r_arready;
    assign w_rd_rgn = f_region(32'(s_axi_araddr), MEM_DEPTH);

    // The RAM is addressed straight from the AR bus during the handshake
    // cycle so its output is ready in R_MEM; a write hitting the same word
    // on that edge is not seen (read-before-write).
    byte_en_ram #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (ACLK),
        .i_we    (w_ram_we),
        .i_waddr (w_wr_addr[IDX_W+1:2]),
        .i_wdata (w_wr_data),
        .i_re    (w_ar_hs && (w_rd_rgn == RGN_MEM)),
        .i_raddr (s_axi_araddr[IDX_W+1:2]),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rresp_nxt   = r_rresp;
        w_rdata_nxt   = r_rdata;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    if (w_rd_rgn == RGN_MEM) begin
                        w_rstate_nxt = R_MEM;
                    end else begin
                        w_rstate_nxt = R_DATA;
                        w_rvalid_nxt = 1'b1;
                        case (w_rd_rgn)
                            RGN_LED: begin
                                w_rdata_nxt = {24'h0, r_leds};
                                w_rresp_nxt = RESP_OKAY;
                            end
                            RGN_ID: begin
                                w_rdata_nxt = ID_VALUE;
                                w_rresp_nxt = RESP_OKAY;
                            end
                            default: begin
                                w_rdata_nxt = 32'h0;
                                w_rresp_nxt = RESP_DECERR;
                            end
                        endcase
                    end
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_MEM: begin
                w_rstate_nxt = R_DATA;
                w_rvalid_nxt = 1'b1;
                w_rdata_nxt  = w_ram_q;
                w_rresp_nxt  = RESP_OKAY;
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    w_rstate_nxt  = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= 32'h0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign leds          = r_leds;

endmodule
`default_nettype wire
